// File: rtl/ltc_parallel_adc_reader.sv
// Parallel SAR ADC reader: CONVST pulse, wait on synchronized BUSY, RD/CS strobe, capture.
// Captured code is returned as {2'b00, code, 2'b00}, the same word format the DAC writer takes.
module ltc_parallel_adc_reader #(
    parameter int unsigned CONVST_CYCLES  = 2,
    parameter int unsigned RD_CYCLES      = 3,
    parameter int unsigned TIMEOUT_CYCLES = 200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [11:0] adc_data,
    input  logic        adc_busy,
    output logic        convst_n,
    output logic        cs_n,
    output logic        rd_n,
    output logic [15:0] sample,
    output logic        sample_valid,
    output logic        busy,
    output logic        timeout_err
);

    localparam logic [7:0]  ConvstLoad = 8'(CONVST_CYCLES);
    localparam logic [7:0]  RdLoad     = 8'(RD_CYCLES);
    localparam logic [15:0] ToLast     = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StConv,
        StWaitHi,
        StWaitLo,
        StRead
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] to_q, to_d;
    logic        bsy_meta_q, bsy_s_q;
    logic        convst_n_q, convst_n_d;
    logic        strobe_n_q, strobe_n_d;
    logic [15:0] sample_q, sample_d;
    logic        sample_valid_q, sample_valid_d;
    logic        busy_q, busy_d;
    logic        timeout_err_q, timeout_err_d;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        to_d           = to_q;
        convst_n_d     = convst_n_q;
        strobe_n_d     = strobe_n_q;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;
        busy_d         = busy_q;
        timeout_err_d  = timeout_err_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    convst_n_d    = 1'b0;
                    busy_d        = 1'b1;
                    timeout_err_d = 1'b0;
                    cnt_d         = ConvstLoad;
                    state_d       = StConv;
                end
            end
            StConv: begin
                if (cnt_q == 8'd1) begin
                    convst_n_d = 1'b1;
                    to_d       = 16'd0;
                    state_d    = StWaitHi;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StWaitHi, StWaitLo: begin
                to_d = to_q + 16'd1;
                // Timeout wins over a BUSY edge seen in the same cycle.
                if (to_q == ToLast) begin
                    timeout_err_d = 1'b1;
                    busy_d        = 1'b0;
                    state_d       = StIdle;
                end else if (state_q == StWaitHi) begin
                    if (bsy_s_q) begin
                        state_d = StWaitLo;
                    end
                end else if (!bsy_s_q) begin
                    strobe_n_d = 1'b0;
                    cnt_d      = RdLoad;
                    state_d    = StRead;
                end
            end
            StRead: begin
                if (cnt_q == 8'd1) begin
                    sample_d       = {2'b00, adc_data, 2'b00};
                    sample_valid_d = 1'b1;
                    strobe_n_d     = 1'b1;
                    busy_d         = 1'b0;
                    state_d        = StIdle;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            cnt_q          <= 8'd0;
            to_q           <= 16'd0;
            bsy_meta_q     <= 1'b0;
            bsy_s_q        <= 1'b0;
            convst_n_q     <= 1'b1;
            strobe_n_q     <= 1'b1;
            sample_q       <= 16'd0;
            sample_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            to_q           <= to_d;
            bsy_meta_q     <= adc_busy;
            bsy_s_q        <= bsy_meta_q;
            convst_n_q     <= convst_n_d;
            strobe_n_q     <= strobe_n_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            busy_q         <= busy_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign convst_n     = convst_n_q;
    assign cs_n         = strobe_n_q;
    assign rd_n         = strobe_n_q;
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign busy         = busy_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_ltc_parallel_adc_reader.sv
// Self-checking bench for ltc_parallel_adc_reader with a behavioural ADC and a pin monitor.
module tb_ltc_parallel_adc_reader;

    localparam int CONV = 2;
    localparam int RD   = 3;
    localparam int TO   = 200;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [11:0] adc_data = 12'h000;
    logic        adc_busy = 1'b0;
    logic        convst_n, cs_n, rd_n, sample_valid, busy, timeout_err;
    logic [15:0] sample;

    int asserts = 0;
    int failures = 0;

    ltc_parallel_adc_reader #(
        .CONVST_CYCLES (CONV),
        .RD_CYCLES     (RD),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .adc_data    (adc_data),
        .adc_busy    (adc_busy),
        .convst_n    (convst_n),
        .cs_n        (cs_n),
        .rd_n        (rd_n),
        .sample      (sample),
        .sample_valid(sample_valid),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Pin monitor: pulse widths, edge times and totals, sampled on the falling edge.
    int   cyc = 0;
    int   sv_total = 0, cs_low_total = 0, convst_fall_total = 0;
    int   convst_run = 0, last_convst_len = 0, rd_run = 0, last_rd_len = 0;
    int   sv_run = 0, last_sv_len = 0;
    int   cs_fall_cyc = 0, convst_rise_cyc = 0, busy_fall_out_cyc = 0;
    logic busy_at_sv = 1'b0, busy_prev_at_sv = 1'b0;
    logic prev_convst = 1'b1, prev_cs = 1'b1, prev_busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        prev_convst <= convst_n;
        prev_cs     <= cs_n;
        prev_busy   <= busy;
        if (convst_n === 1'b0) convst_run <= convst_run + 1;
        else if (convst_run != 0) begin
            last_convst_len <= convst_run;
            convst_run      <= 0;
        end
        if (convst_n === 1'b0 && prev_convst === 1'b1) convst_fall_total <= convst_fall_total + 1;
        if (convst_n === 1'b1 && prev_convst === 1'b0) convst_rise_cyc <= cyc;
        if (rd_n === 1'b0) rd_run <= rd_run + 1;
        else if (rd_run != 0) begin
            last_rd_len <= rd_run;
            rd_run      <= 0;
        end
        if (cs_n === 1'b0) cs_low_total <= cs_low_total + 1;
        if (cs_n === 1'b0 && prev_cs === 1'b1) cs_fall_cyc <= cyc;
        if (busy === 1'b0 && prev_busy === 1'b1) busy_fall_out_cyc <= cyc;
        if (sample_valid === 1'b1) begin
            sv_total        <= sv_total + 1;
            sv_run          <= sv_run + 1;
            busy_at_sv      <= busy;
            busy_prev_at_sv <= prev_busy;
        end else if (sv_run != 0) begin
            last_sv_len <= sv_run;
            sv_run      <= 0;
        end
    end

    int   busy_fall_cyc = 0;
    logic got_sv;

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_convst_rise();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (convst_n === 1'b1) break;
        end
    endtask

    task automatic wait_sv();
        got_sv = 1'b0;
        for (int i = 0; i < 100 && !got_sv; i++) begin
            @(negedge clk);
            if (sample_valid === 1'b1) got_sv = 1'b1;
        end
        @(negedge clk); #1;
    endtask

    // ADC model: BUSY rises one cycle after CONVST rises, holds h cycles, then data is valid.
    task automatic run_conv(input logic [11:0] code, input int h);
        pulse_start();
        wait_convst_rise();
        @(posedge clk); #1 adc_busy = 1'b1;
        repeat (h) @(posedge clk);
        #1 adc_busy = 1'b0;
        adc_data      = code;
        busy_fall_cyc = cyc;
        wait_sv();
    endtask

    task automatic test_reset();
        asserts += 7;
        if (convst_n !== 1'b1) begin failures++; $display("FAIL reset_convst_n got %b want 1", convst_n); end
        if (cs_n !== 1'b1) begin failures++; $display("FAIL reset_cs_n got %b want 1", cs_n); end
        if (rd_n !== 1'b1) begin failures++; $display("FAIL reset_rd_n got %b want 1", rd_n); end
        if (sample !== 16'h0000) begin failures++; $display("FAIL reset_sample got %h want 0000", sample); end
        if (sample_valid !== 1'b0) begin failures++; $display("FAIL reset_sv got %b want 0", sample_valid); end
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
        if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_toerr got %b want 0", timeout_err); end
    endtask

    task automatic test_nominal();
        run_conv(12'hA5C, 20);
        asserts += 7;
        if (!got_sv) begin failures++; $display("FAIL nom_sv_seen got 0 want 1"); end
        if (last_convst_len != CONV) begin failures++; $display("FAIL nom_convst_len got %0d want %0d", last_convst_len, CONV); end
        if (last_rd_len != RD) begin failures++; $display("FAIL nom_rd_len got %0d want %0d", last_rd_len, RD); end
        if (sample !== 16'h2970) begin failures++; $display("FAIL nom_sample got %h want 2970", sample); end
        if (last_sv_len != 1) begin failures++; $display("FAIL nom_sv_width got %0d want 1", last_sv_len); end
        if (busy_at_sv !== 1'b0 || busy_prev_at_sv !== 1'b1) begin
            failures++; $display("FAIL nom_busy_edge got %b%b want 10", busy_prev_at_sv, busy_at_sv);
        end
        if (cs_fall_cyc - busy_fall_cyc != 3) begin
            failures++; $display("FAIL nom_cs_gap got %0d want 3", cs_fall_cyc - busy_fall_cyc);
        end
    endtask

    task automatic test_round_trip();
        logic [11:0] codes [3];
        codes[0] = 12'h000; codes[1] = 12'hFFF; codes[2] = 12'h800;
        for (int i = 0; i < 3; i++) begin
            run_conv(codes[i], 5 + i);
            asserts += 3;
            if (sample[13:2] !== codes[i]) begin failures++; $display("FAIL rt_code got %h want %h", sample[13:2], codes[i]); end
            if (sample[15:14] !== 2'b00 || sample[1:0] !== 2'b00) begin
                failures++; $display("FAIL rt_pad got %h want pad bits 0", sample);
            end
            if (!got_sv) begin failures++; $display("FAIL rt_sv_seen got 0 want 1"); end
        end
        asserts++;
        if (sample !== 16'h0000 + 16'(12'h800) * 16'd4) begin failures++; $display("FAIL rt_800 got %h want 2000", sample); end
        run_conv(12'hFFF, 3);
        asserts++;
        if (sample !== 16'h3FFC) begin failures++; $display("FAIL rt_fff got %h want 3ffc", sample); end
    endtask

    task automatic test_back_to_back();
        logic [11:0] code;
        int          h;
        for (int n = 0; n < 8; n++) begin
            code = 12'($urandom_range(0, 4095));
            h    = $urandom_range(1, 120);
            run_conv(code, h);
            asserts += 4;
            if (!got_sv) begin failures++; $display("FAIL b2b_sv_seen iter %0d got 0 want 1", n); end
            if (sample !== 16'(code) * 16'd4) begin failures++; $display("FAIL b2b_sample got %h want %h", sample, 16'(code) * 16'd4); end
            if (cs_fall_cyc - busy_fall_cyc != 3) begin
                failures++; $display("FAIL b2b_cs_gap got %0d want 3", cs_fall_cyc - busy_fall_cyc);
            end
            if (last_rd_len != RD) begin failures++; $display("FAIL b2b_rd_len got %0d want %0d", last_rd_len, RD); end
        end
    endtask

    // level: value adc_busy is held at for the whole attempt.
    task automatic test_timeout(input logic level, input string tag);
        int   sv0, cs0;
        logic done;
        adc_busy = level;
        sv0 = sv_total; cs0 = cs_low_total;
        pulse_start();
        wait_convst_rise();
        done = 1'b0;
        for (int i = 0; i < TO + 50 && !done; i++) begin
            @(negedge clk);
            if (busy === 1'b0) done = 1'b1;
        end
        #1;
        asserts += 5;
        if (!done) begin failures++; $display("FAIL %s_abort got busy=%b want 0", tag, busy); end
        if (timeout_err !== 1'b1) begin failures++; $display("FAIL %s_toerr got %b want 1", tag, timeout_err); end
        if (sv_total != sv0) begin failures++; $display("FAIL %s_no_sv got %0d want 0", tag, sv_total - sv0); end
        if (cs_low_total != cs0) begin failures++; $display("FAIL %s_no_strobe got %0d want 0", tag, cs_low_total - cs0); end
        if (busy_fall_out_cyc - convst_rise_cyc != TO) begin
            failures++; $display("FAIL %s_to_time got %0d want %0d", tag, busy_fall_out_cyc - convst_rise_cyc, TO);
        end
        adc_busy = 1'b0;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_timeout_clear();
        pulse_start();
        @(negedge clk);
        asserts++;
        if (timeout_err !== 1'b0) begin failures++; $display("FAIL clr_on_start got %b want 0", timeout_err); end
        wait_convst_rise();
        @(posedge clk); #1 adc_busy = 1'b1;
        repeat (6) @(posedge clk);
        #1 adc_busy = 1'b0; adc_data = 12'h123;
        wait_sv();
        asserts += 2;
        if (timeout_err !== 1'b0) begin failures++; $display("FAIL clr_after got %b want 0", timeout_err); end
        if (sample !== 16'h048C) begin failures++; $display("FAIL clr_sample got %h want 048c", sample); end
    endtask

    task automatic test_start_while_busy();
        int sv0, cf0;
        sv0 = sv_total; cf0 = convst_fall_total;
        pulse_start();
        #1 start = 1'b1;            // during CONV
        @(posedge clk); #1 start = 1'b0;
        wait_convst_rise();
        @(posedge clk); #1 adc_busy = 1'b1;
        repeat (10) @(posedge clk);
        #1 start = 1'b1;            // during WAIT_LO
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 adc_busy = 1'b0; adc_data = 12'h3C3;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rd_n === 1'b0) break;
        end
        @(posedge clk); #1 start = 1'b1; // during READ
        @(posedge clk); #1 start = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        asserts += 3;
        if (sv_total - sv0 != 1) begin failures++; $display("FAIL swb_sv_count got %0d want 1", sv_total - sv0); end
        if (convst_fall_total - cf0 != 1) begin failures++; $display("FAIL swb_conv_count got %0d want 1", convst_fall_total - cf0); end
        if (sample !== 16'h0F0C) begin failures++; $display("FAIL swb_sample got %h want 0f0c", sample); end
    endtask

    task automatic test_reset_mid_read();
        int   sv0;
        logic in_read;
        pulse_start();
        wait_convst_rise();
        @(posedge clk); #1 adc_busy = 1'b1;
        repeat (5) @(posedge clk);
        #1 adc_busy = 1'b0; adc_data = 12'h7E1;
        in_read = 1'b0;
        for (int i = 0; i < 20 && !in_read; i++) begin
            @(negedge clk);
            if (rd_n === 1'b0) in_read = 1'b1;
        end
        sv0 = sv_total;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        asserts += 7;
        if (!in_read) begin failures++; $display("FAIL rmr_reached_read got 0 want 1"); end
        if (rd_n !== 1'b1 || cs_n !== 1'b1) begin failures++; $display("FAIL rmr_strobe got %b%b want 11", rd_n, cs_n); end
        if (convst_n !== 1'b1) begin failures++; $display("FAIL rmr_convst got %b want 1", convst_n); end
        if (busy !== 1'b0) begin failures++; $display("FAIL rmr_busy got %b want 0", busy); end
        if (sample !== 16'h0000) begin failures++; $display("FAIL rmr_sample got %h want 0000", sample); end
        if (sample_valid !== 1'b0) begin failures++; $display("FAIL rmr_sv got %b want 0", sample_valid); end
        repeat (10) @(posedge clk);
        #1;
        if (sv_total != sv0) begin failures++; $display("FAIL rmr_no_sv got %0d want 0", sv_total - sv0); end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        test_nominal();
        test_round_trip();
        test_back_to_back();
        test_timeout(1'b0, "to_never");
        test_timeout_clear();
        test_timeout(1'b1, "to_stuck");
        test_start_while_busy();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule

// File: doc/ltc_parallel_adc_reader.md
# ltc_parallel_adc_reader

Drives a parallel-output SAR ADC through one conversion-and-read cycle per `start` pulse: CONVST, wait on ADC BUSY, RD/CS read strobe, capture. It is the acquisition-side counterpart of the parallel DAC writer and sits between the ADC pins and the fixed-point datapath. It returns each 12-bit code placed in the same 16-bit word format the DAC writer consumes, so a code read here and written there round-trips unchanged. Conversion timeouts are detected and flagged instead of hanging.

## Interface
Parameters:
- `CONVST_CYCLES`, 2: cycles `convst_n` is held low; legal range 1-255.
- `RD_CYCLES`, 3: cycles `cs_n`/`rd_n` are held low before capture (covers ADC access time); legal range 1-255.
- `TIMEOUT_CYCLES`, 200: maximum cycles spent waiting on ADC BUSY before aborting; legal range 4-65535.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle request for a conversion; ignored unless in IDLE.
- `adc_data`  in  12  ADC parallel output bus.
- `adc_busy`  in  1  ADC BUSY, active-high, asynchronous to `clk`.
- `convst_n`  out  1  conversion start, active-low.
- `cs_n`  out  1  chip select, active-low.
- `rd_n`  out  1  read strobe, active-low.
- `sample`  out  16  captured code: `{2'b00, code[11:0], 2'b00}`, so `sample[13:2]` = code.
- `sample_valid`  out  1  one-cycle pulse when `sample` updates.
- `busy`  out  1  high from accepted start until completion or abort.
- `timeout_err`  out  1  sticky abort flag; cleared by the next accepted start.

## Operation
- `adc_busy` passes through a 2-flop synchronizer; both flops reset to 0. All decisions use the synchronized value `bsy_s`.
- **IDLE**
  - On `start`: `convst_n`=0, `busy`=1, `timeout_err`=0, load the CONVST counter, go to CONV.
- **CONV**
  - Hold `convst_n` low for exactly `CONVST_CYCLES` cycles.
  - Then `convst_n`=1, clear the timeout counter, go to WAIT_HI.
- **WAIT_HI**
  - Wait for `bsy_s`=1, then go to WAIT_LO.
  - This state guards against reading before the ADC has registered the conversion.
- **WAIT_LO**
  - Wait for `bsy_s`=0, then `cs_n`=0, `rd_n`=0, load the RD counter, go to READ.
- **Timeout**
  - The timeout counter runs continuously through WAIT_HI and WAIT_LO.
  - When it reaches `TIMEOUT_CYCLES`: `timeout_err`=1, `busy`=0, no `sample_valid`, return to IDLE.
  - Timeout takes priority over a `bsy_s` transition in the same cycle.
- **READ**
  - `cs_n`/`rd_n` stay low for exactly `RD_CYCLES` cycles.
  - On the final edge, all of the following happen together: `sample` <= `{2'b00, adc_data, 2'b00}`, `sample_valid`=1, `cs_n`=`rd_n`=1, `busy`=0, go to IDLE.
- `sample_valid` is high for exactly one cycle. `sample` holds its value until the next capture.
- `start` is ignored in every state except IDLE. A `start` in the same cycle as completion is ignored; the next `start` is accepted in IDLE.
- `reset` mid-operation forces all outputs to their reset values and the state to IDLE on the next edge. Any conversion in flight is abandoned and no `sample_valid` is produced.

## Timing
- Reset values: `convst_n`=1, `cs_n`=1, `rd_n`=1, `sample`=0, `sample_valid`=0, `busy`=0, `timeout_err`=0, state IDLE.
- `start` sampled high at edge E0: `convst_n` and `busy` are high-to-low starting E0+1-cycle; `convst_n` low for cycles E0..E0+CONVST_CYCLES-1 after the edge.
- `bsy_s` lags `adc_busy` by 2 cycles.
- The WAIT_LO exit edge drives `cs_n`/`rd_n` low, 3 cycles after `adc_busy` falls (2 sync cycles plus 1 registered decision).
- `sample_valid` rises `RD_CYCLES` edges after `cs_n` falls.
- Minimum start-to-`sample_valid` latency is `CONVST_CYCLES` + 1 + (busy high duration + 2) + 1 + `RD_CYCLES` cycles.
- Minimum spacing between accepted starts is that latency + 1.

## Test plan
- **Nominal conversion:** `start`; ADC model raises `adc_busy` 1 cycle after `convst_n` rises, holds it 20 cycles, then drives `adc_data`=12'hA5C. Require `convst_n` low exactly 2 cycles, `rd_n` low exactly 3 cycles, `sample`=16'h2970, `sample_valid` pulse width 1, `busy` falling on the same edge.
- **Round trip:** codes 12'h000, 12'hFFF, 12'h800. Require `sample[13:2]` equals the code and `sample[15:14]`=`sample[1:0]`=0. For 12'hFFF, `sample`=16'h3FFC.
- **Busy never asserts:** `adc_busy` held 0. Require `timeout_err`=1 and `busy`=0 after `TIMEOUT_CYCLES` cycles in WAIT_HI, no `sample_valid`, and `cs_n`/`rd_n` never low. A following good conversion clears `timeout_err`.
- **Busy stuck high:** `adc_busy` held 1. Require a timeout and no read strobe.
- **Start while busy:** `start` pulses during CONV, WAIT_LO and READ. Require only one conversion and exactly one `sample_valid`.
- **Reset mid-READ:** assert `reset` while `rd_n`=0. Require the next edge gives `rd_n`=`cs_n`=`convst_n`=1, `busy`=0, `sample`=0, and no `sample_valid`.
